// File: rtl/store_queue.sv
// store_queue: circular store buffer split into committed and speculative regions, with drain and load probe.
// Define STORE_QUEUE_FWD_EN for youngest-entry data forwarding; otherwise a matching load only sees a conflict.
module store_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq_valid,
    input  logic [6:0]              enq_id,
    input  logic                    enq_cache,
    input  logic [31:0]             enq_addr,
    input  logic [1:0]              enq_size,
    input  logic [31:0]             enq_data,
    output logic                    enq_ready,
    input  logic [$clog2(CW+1)-1:0] com_cnt,
    input  logic                    rb,
    output logic                    drn_valid,
    output logic                    drn_cache,
    output logic [31:0]             drn_addr,
    output logic [1:0]              drn_size,
    output logic [31:0]             drn_data,
    output logic [3:0]              drn_strobe,
    input  logic                    drn_ready,
    output logic                    empty,
    output logic                    half,
    output logic                    full,
    input  logic [31:0]             ld_addr,
    input  logic [1:0]              ld_size,
    output logic                    fwd_hit,
    output logic [31:0]             fwd_data,
    output logic                    fwd_conflict
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int CNTW = $clog2(CW + 1);
    localparam int MW   = (CNTW > PW) ? CNTW : PW;

    typedef logic [PW-1:0] ptr_t;

    ptr_t head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    ptr_t occ, spec;
    logic push, pop;
    logic [MW-1:0] com_w, spec_w, commit;

    logic        ram_cache [DEPTH];
    logic [31:0] ram_addr  [DEPTH];
    logic [1:0]  ram_size  [DEPTH];
    logic [31:0] ram_data  [DEPTH];

    function automatic logic [3:0] strobe_of(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd1:    strobe_of = 4'b0001 << lo;
            2'd2:    strobe_of = lo[1] ? 4'b1100 : 4'b0011;
            2'd3:    strobe_of = 4'b1111;
            default: strobe_of = 4'b0000;
        endcase
    endfunction

    assign occ       = tail_q - head_q;
    assign full      = (occ == PW'(DEPTH));
    assign empty     = (occ == '0);
    assign half      = (occ >= PW'(DEPTH / 2));
    assign enq_ready = !full;
    assign drn_valid = (head_q != cmt_q);
    assign push      = enq_valid && !full && !rb;
    assign pop       = drn_valid && drn_ready;

    always_comb begin
        spec   = tail_q - cmt_q;
        com_w  = MW'(com_cnt);
        spec_w = MW'(spec);
        commit = (com_w < spec_w) ? com_w : spec_w;
        head_d = head_q + PW'(pop);
        cmt_d  = cmt_q + PW'(commit);
        // Rollback trims to the commit point after this cycle's commit has landed.
        tail_d = rb ? cmt_d : tail_q + PW'(push);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
        end
    end

    // NOTE: payload RAM is not reset; the pointers alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            ram_cache[tail_q[AW-1:0]] <= enq_cache;
            ram_addr[tail_q[AW-1:0]]  <= enq_addr;
            ram_size[tail_q[AW-1:0]]  <= enq_size;
            ram_data[tail_q[AW-1:0]]  <= enq_data;
        end
    end

    assign drn_cache  = ram_cache[head_q[AW-1:0]];
    assign drn_addr   = ram_addr[head_q[AW-1:0]];
    assign drn_size   = ram_size[head_q[AW-1:0]];
    assign drn_data   = ram_data[head_q[AW-1:0]];
    assign drn_strobe = strobe_of(drn_size, drn_addr[1:0]);

    logic [AW-1:0] idx;
    logic          live;
    logic          match;

`ifdef STORE_QUEUE_FWD_EN
    logic [3:0]  ld_strobe;
    logic [3:0]  ent_strobe;
    logic        found;
    logic        y_cover;
    logic [31:0] y_data;
    logic        unused_id;

    assign unused_id = ^enq_id;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        ld_strobe  = strobe_of(ld_size, ld_addr[1:0]);
        found      = 1'b0;
        y_cover    = 1'b0;
        y_data     = '0;
        idx        = '0;
        live       = 1'b0;
        match      = 1'b0;
        ent_strobe = '0;
        // Walk oldest to youngest so the last overlapping entry is the one kept.
        for (int i = 0; i < DEPTH; i++) begin
            idx        = head_q[AW-1:0] + AW'(i);
            live       = (PW'(i) < occ);
            ent_strobe = strobe_of(ram_size[idx], ram_addr[idx][1:0]);
            match      = live && (ram_addr[idx][31:2] == ld_addr[31:2])
                         && ((ent_strobe & ld_strobe) != 4'b0000);
            if (match) begin
                found   = 1'b1;
                y_cover = ram_cache[idx] && ((ent_strobe & ld_strobe) == ld_strobe);
                y_data  = ram_data[idx];
            end
        end
        fwd_hit      = found && y_cover;
        fwd_conflict = found && !y_cover;
        fwd_data     = fwd_hit ? y_data : '0;
    end
`else
    logic unused_ld;

    assign unused_ld = ^{enq_id, ld_size, ld_addr[1:0]};
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;

    always_comb begin
        fwd_conflict = 1'b0;
        idx          = '0;
        live         = 1'b0;
        match        = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx   = head_q[AW-1:0] + AW'(i);
            live  = (PW'(i) < occ);
            match = live && (ram_addr[idx][31:2] == ld_addr[31:2]);
            if (match) fwd_conflict = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: fill/full, commit and drain order, rollback, forwarding probes, reset mid-drain.
module tb_store_queue;
    localparam int DEPTH = 8;
    localparam int CW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic [6:0]  enq_id;
    logic        enq_cache;
    logic [31:0] enq_addr;
    logic [1:0]  enq_size;
    logic [31:0] enq_data;
    logic        enq_ready;
    logic [1:0]  com_cnt;
    logic        rb;
    logic        drn_valid;
    logic        drn_cache;
    logic [31:0] drn_addr;
    logic [1:0]  drn_size;
    logic [31:0] drn_data;
    logic [3:0]  drn_strobe;
    logic        drn_ready;
    logic        empty;
    logic        half;
    logic        full;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_conflict;

    int n_chk = 0;
    int n_err = 0;

    store_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_id(enq_id), .enq_cache(enq_cache), .enq_addr(enq_addr),
        .enq_size(enq_size), .enq_data(enq_data), .enq_ready(enq_ready),
        .com_cnt(com_cnt), .rb(rb),
        .drn_valid(drn_valid), .drn_cache(drn_cache), .drn_addr(drn_addr), .drn_size(drn_size),
        .drn_data(drn_data), .drn_strobe(drn_strobe), .drn_ready(drn_ready),
        .empty(empty), .half(half), .full(full),
        .ld_addr(ld_addr), .ld_size(ld_size),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_conflict(fwd_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic cache, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] data);
        enq_valid = 1'b1;
        enq_cache = cache;
        enq_addr  = addr;
        enq_size  = size;
        enq_data  = data;
        step();
        enq_valid = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic hit, input logic conflict, input logic [31:0] data);
        ld_addr = addr;
        ld_size = size;
        #1;
        check({tag, "_hit"}, 32'(fwd_hit), 32'(hit));
        check({tag, "_conflict"}, 32'(fwd_conflict), 32'(conflict));
        check({tag, "_data"}, fwd_data, data);
    endtask

    task automatic drain_expect(input logic [31:0] first, input int n);
        int got;
        got = 0;
        drn_ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH && drn_valid; k++) begin
            check("drain_data", drn_data, first + 32'(got));
            got++;
            step();
        end
        drn_ready = 1'b0;
        check("drain_count", 32'(got), 32'(n));
        check("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enq_valid = 1'b0; enq_id = '0; enq_cache = 1'b1; enq_addr = '0;
        enq_size = 2'd3; enq_data = '0; com_cnt = '0; rb = 1'b0; drn_ready = 1'b0;
        ld_addr = 32'h0000_0F00; ld_size = 2'd3;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_half", 32'(half), 32'd0);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_drn_valid", 32'(drn_valid), 32'd0);
        check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        check("rst_fwd_conflict", 32'(fwd_conflict), 32'd0);

        // Fill with 8 word stores, no commit
        for (int i = 0; i < DEPTH; i++) begin
            push(1'b1, 32'h100 + 32'(4 * i), 2'd3, 32'(i));
            if (i == 2) check("half_at_3", 32'(half), 32'd0);
            if (i == 3) check("half_at_4", 32'(half), 32'd1);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_enq_ready", 32'(enq_ready), 32'd0);
        check("fill_drn_valid", 32'(drn_valid), 32'd0);
        push(1'b1, 32'h999, 2'd3, 32'h99);
        check("ninth_full", 32'(full), 32'd1);
        com_cnt = 2'd2;
        for (int i = 0; i < DEPTH / 2; i++) step();
        com_cnt = 2'd0;
        check("commit_drn_valid", 32'(drn_valid), 32'd1);
        check("commit_drn_data", drn_data, 32'd0);
        check("commit_drn_addr", drn_addr, 32'h100);
        check("commit_drn_strobe", 32'(drn_strobe), 32'hF);
        // Push while full with a simultaneous pop: push must be dropped
        drn_ready = 1'b1;
        push(1'b1, 32'h0EE0, 2'd3, 32'hEE);
        drn_ready = 1'b0;
        check("popfull_full", 32'(full), 32'd0);
        drain_expect(32'd1, 7);

        // Three pushes, commit two: only two drain; excess commit saturates
        push(1'b1, 32'h200, 2'd3, 32'hA0);
        push(1'b1, 32'h205, 2'd1, 32'hA1);
        push(1'b1, 32'h20A, 2'd2, 32'hA2);
        com_cnt = 2'd2;
        step();
        com_cnt = 2'd0;
        check("c2_drn_valid", 32'(drn_valid), 32'd1);
        check("c2_drn_data0", drn_data, 32'hA0);
        drn_ready = 1'b1;
        step();
        check("c2_drn_data1", drn_data, 32'hA1);
        check("c2_strobe_byte", 32'(drn_strobe), 32'h2);
        step();
        drn_ready = 1'b0;
        check("c2_third_held", 32'(drn_valid), 32'd0);
        check("c2_not_empty", 32'(empty), 32'd0);
        com_cnt = 2'd2;
        step();
        com_cnt = 2'd0;
        check("sat_drn_data", drn_data, 32'hA2);
        check("sat_strobe_half", 32'(drn_strobe), 32'hC);
        drn_ready = 1'b1;
        step();
        drn_ready = 1'b0;
        check("sat_empty", 32'(empty), 32'd1);
        push(1'b1, 32'h300, 2'd3, 32'hA3);
        check("sat_no_overshoot", 32'(drn_valid), 32'd0);
        rb = 1'b1;
        step();
        rb = 1'b0;
        check("rb_clear_empty", 32'(empty), 32'd1);

        // Rollback with a same-cycle commit keeps two committed entries
        for (int i = 0; i < 4; i++) push(1'b1, 32'h400 + 32'(4 * i), 2'd3, 32'hB0 + 32'(i));
        com_cnt = 2'd1;
        step();
        rb = 1'b1;
        enq_valid = 1'b1;
        enq_data  = 32'hBF;
        step();
        rb = 1'b0; enq_valid = 1'b0; com_cnt = 2'd0;
        check("rb_empty", 32'(empty), 32'd0);
        check("rb_half", 32'(half), 32'd0);
        check("rb_drn_data", drn_data, 32'hB0);
        drain_expect(32'hB0, 2);

        // Forwarding probes
        push(1'b1, 32'h1000, 2'd3, 32'hAABBCCDD);
        push(1'b1, 32'h1001, 2'd1, 32'h00001100);
`ifdef STORE_QUEUE_FWD_EN
        probe("ld_b1001", 32'h1001, 2'd1, 1'b1, 1'b0, 32'h00001100);
        probe("ld_w1000", 32'h1000, 2'd3, 1'b0, 1'b1, 32'h0);
        probe("ld_b1002", 32'h1002, 2'd1, 1'b1, 1'b0, 32'hAABBCCDD);
`else
        probe("ld_b1001", 32'h1001, 2'd1, 1'b0, 1'b1, 32'h0);
        probe("ld_w1000", 32'h1000, 2'd3, 1'b0, 1'b1, 32'h0);
        probe("ld_b1002", 32'h1002, 2'd1, 1'b0, 1'b1, 32'h0);
`endif
        probe("ld_miss", 32'h3000, 2'd3, 1'b0, 1'b0, 32'h0);
        push(1'b0, 32'h2000, 2'd3, 32'h12345678);
        probe("ld_uncache", 32'h2002, 2'd2, 1'b0, 1'b1, 32'h0);
        rb = 1'b1;
        step();
        rb = 1'b0;
        check("fwd_rb_empty", 32'(empty), 32'd1);
        probe("ld_after_rb", 32'h1000, 2'd3, 1'b0, 1'b0, 32'h0);

        // Stalled drain then reset drops the entry
        push(1'b1, 32'h4000, 2'd3, 32'h5555AAAA);
        com_cnt = 2'd1;
        step();
        com_cnt = 2'd0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(drn_valid), 32'd1);
            check("stall_data", drn_data, 32'h5555AAAA);
            step();
        end
        ld_addr = 32'h4000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_drn_valid", 32'(drn_valid), 32'd0);
        check("rst2_empty", 32'(empty), 32'd1);
        check("rst2_enq_ready", 32'(enq_ready), 32'd1);
        check("rst2_fwd_conflict", 32'(fwd_conflict), 32'd0);
        check("rst2_fwd_hit", 32'(fwd_hit), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
